// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clock_div_pkg;

  localparam int DIV_WIDTH = 28;

  typedef logic [DIV_WIDTH-1:0] div_t;

  typedef struct packed {
    div_t div;
    div_t high;
  } div_cfg_t;

  // A period shorter than two cycles cannot carry both a high and a low phase.
  function automatic div_t clamp_div(input div_t d);
    return (d < div_t'(2)) ? div_t'(2) : d;
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Configuration and output bundle of the multi-channel clock divider.
interface clock_divider_multi_if #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = clock_div_pkg::DIV_WIDTH
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // cfg_valid is a one-cycle write strobe with no ready: every write is
  // accepted in the cycle it is presented, with cfg_ch/cfg_div/cfg_high
  // qualified by cfg_valid. Outputs are registered and never stall.
  logic [CHANNELS-1:0]  enable;
  logic                 cfg_valid;
  logic [CH_W-1:0]      cfg_ch;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [DIV_WIDTH-1:0] cfg_high;
  logic [CHANNELS-1:0]  clock_out;
  logic [CHANNELS-1:0]  tick;
  logic [CHANNELS-1:0]  cfg_pending;

  modport master (
    output enable, cfg_valid, cfg_ch, cfg_div, cfg_high,
    input  clock_out, tick, cfg_pending
  );

  modport slave (
    input  enable, cfg_valid, cfg_ch, cfg_div, cfg_high,
    output clock_out, tick, cfg_pending
  );

endinterface

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, active/shadow configuration and
// pending flag; new configuration only lands on a period boundary.
module clock_divider_channel
  import clock_div_pkg::*;
#(
  parameter div_t DEFAULT_DIV = div_t'(8)
) (
  input  logic     clock_in,
  input  logic     reset,
  input  logic     en,
  input  logic     wr,
  input  div_cfg_t wr_cfg,
  output logic     clock_out,
  output logic     tick,
  output logic     cfg_pending
);

  localparam div_cfg_t RESET_CFG = '{div: clamp_div(DEFAULT_DIV), high: DEFAULT_DIV >> 1};

  div_t     cnt;
  div_cfg_t act;
  div_cfg_t shd;
  div_cfg_t new_cfg;
  logic     wrap;
  logic     apply_now;

  assign wrap      = (cnt >= act.div - div_t'(1));
  // A disabled channel sits on a period boundary, so it accepts config at once.
  assign apply_now = !en || wrap;
  assign new_cfg   = '{div: clamp_div(wr_cfg.div), high: wr_cfg.high};

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt         <= '0;
      act         <= RESET_CFG;
      shd         <= RESET_CFG;
      cfg_pending <= 1'b0;
      clock_out   <= 1'b0;
      tick        <= 1'b0;
    end else begin
      if (en) begin
        clock_out <= (cnt < act.high);
        tick      <= (cnt == '0);
        cnt       <= wrap ? '0 : cnt + div_t'(1);
      end else begin
        clock_out <= 1'b0;
        tick      <= 1'b0;
        cnt       <= '0;
      end

      // A write landing on a boundary bypasses the shadow and never shows as pending.
      if (wr) begin
        shd <= new_cfg;
        if (apply_now) begin
          act         <= new_cfg;
          cfg_pending <= 1'b0;
        end else begin
          cfg_pending <= 1'b1;
        end
      end else if (apply_now && cfg_pending) begin
        act         <= shd;
        cfg_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider / enable generator: write decode plus one
// independent divider channel per output.
module clock_divider_multi #(
  parameter int                   CHANNELS    = 4,
  parameter int                   DIV_WIDTH   = clock_div_pkg::DIV_WIDTH,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(8)
) (
  input logic                  clock_in,
  input logic                  reset,
  clock_divider_multi_if.slave ch_if
);
  import clock_div_pkg::*;

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] co;
  logic [CHANNELS-1:0] tk;
  logic [CHANNELS-1:0] pd;
  logic                ch_in_range;
  div_cfg_t            wr_cfg;

  assign ch_in_range = ({1'b0, ch_if.cfg_ch} < (CH_W + 1)'(CHANNELS));
  assign wr_cfg      = '{div: ch_if.cfg_div, high: ch_if.cfg_high};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    assign wr = ch_if.cfg_valid && ch_in_range && (ch_if.cfg_ch == CH_W'(i));

    clock_divider_channel #(
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock_in    (clock_in),
      .reset       (reset),
      .en          (ch_if.enable[i]),
      .wr          (wr),
      .wr_cfg      (wr_cfg),
      .clock_out   (co[i]),
      .tick        (tk[i]),
      .cfg_pending (pd[i])
    );
  end

  assign ch_if.clock_out   = co;
  assign ch_if.tick        = tk;
  assign ch_if.cfg_pending = pd;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios followed by random traffic,
// every cycle compared against a period/phase reference model.
module tb_clock_divider_multi;
  import clock_div_pkg::*;

  localparam int CH = 4;

  logic clock_in = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock_in = ~clock_in;

  clock_divider_multi_if #(.CHANNELS(CH), .DIV_WIDTH(DIV_WIDTH)) dif ();
  clock_divider_multi_if #(.CHANNELS(3),  .DIV_WIDTH(DIV_WIDTH)) dif3 ();

  clock_divider_multi #(.CHANNELS(CH)) dut  (.clock_in(clock_in), .reset(reset), .ch_if(dif));
  clock_divider_multi #(.CHANNELS(3))  dut3 (.clock_in(clock_in), .reset(reset), .ch_if(dif3));

  // Reference model: phase within the current period and the config governing it.
  int m_pos[CH], m_div[CH], m_high[CH], m_sdiv[CH], m_shigh[CH];
  bit m_pend[CH];
  logic [CH-1:0] exp_co, exp_tick, exp_pend;
  int k3;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit boundary, wr;
    int d;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_pos[c] = 0; m_div[c] = 8; m_high[c] = 4;
        m_sdiv[c] = 8; m_shigh[c] = 4; m_pend[c] = 0;
      end
      exp_co = '0; exp_tick = '0; exp_pend = '0; k3 = 0;
    end else begin
      k3++;
      for (int c = 0; c < CH; c++) begin
        boundary  = !dif.enable[c] || (m_pos[c] == m_div[c] - 1);
        exp_co[c]   = dif.enable[c] && (m_pos[c] < m_high[c]);
        exp_tick[c] = dif.enable[c] && (m_pos[c] == 0);
        m_pos[c]    = boundary ? 0 : m_pos[c] + 1;
        wr = dif.cfg_valid && (int'(dif.cfg_ch) == c);
        if (wr) begin
          d = (dif.cfg_div < 2) ? 2 : int'(dif.cfg_div);
          if (boundary) begin
            m_div[c] = d; m_high[c] = int'(dif.cfg_high); m_pend[c] = 0;
          end else begin
            m_sdiv[c] = d; m_shigh[c] = int'(dif.cfg_high); m_pend[c] = 1;
          end
        end else if (boundary && m_pend[c]) begin
          m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
        end
        exp_pend[c] = m_pend[c];
      end
    end
  endtask

  task automatic step();
    int p;
    logic [2:0] e3_co, e3_tk;
    @(posedge clock_in);
    model_edge();
    #1;
    check("clock_out", 32'(dif.clock_out), 32'(exp_co));
    check("tick", 32'(dif.tick), 32'(exp_tick));
    check("cfg_pending", 32'(dif.cfg_pending), 32'(exp_pend));
    // The 3-channel instance only ever runs the reset default, always enabled.
    p = (k3 - 1) % 8;
    e3_co = (k3 > 0 && p < 4) ? 3'b111 : 3'b000;
    e3_tk = (k3 > 0 && p == 0) ? 3'b111 : 3'b000;
    check("dut3_clock_out", 32'(dif3.clock_out), 32'(e3_co));
    check("dut3_tick", 32'(dif3.tick), 32'(e3_tk));
    check("dut3_cfg_pending", 32'(dif3.cfg_pending), 32'(0));
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic write_cfg(int ch, int d, int h);
    dif.cfg_valid = 1'b1;
    dif.cfg_ch    = 2'(ch);
    dif.cfg_div   = DIV_WIDTH'(d);
    dif.cfg_high  = DIV_WIDTH'(h);
    step();
    dif.cfg_valid = 1'b0;
  endtask

  task automatic wait_pos(int ch, int p);
    int n = 0;
    while (m_pos[ch] != p && n < 100) begin
      step();
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $error("FAIL wait_pos ch=%0d observed=timeout expected=pos %0d", ch, p);
    end
  endtask

  task automatic tick_gap(int ch, output int gap);
    int n = 0;
    do begin step(); n++; end while (!dif.tick[ch] && n < 200);
    n = 0;
    do begin step(); n++; end while (!dif.tick[ch] && n < 200);
    gap = n;
  endtask

  task automatic count_high(int ch, int n, output int hi, output int ticks);
    hi = 0; ticks = 0;
    repeat (n) begin
      step();
      hi    += int'(dif.clock_out[ch]);
      ticks += int'(dif.tick[ch]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, hi, tks;
    reset = 1'b1;
    dif.enable = '0; dif.cfg_valid = 1'b0; dif.cfg_ch = '0; dif.cfg_div = '0; dif.cfg_high = '0;
    dif3.enable = 3'b111; dif3.cfg_valid = 1'b0; dif3.cfg_ch = '0; dif3.cfg_div = '0; dif3.cfg_high = '0;

    // 1: reset state and default 8-cycle period, 4 high
    run(2);
    check("reset_clock_out", 32'(dif.clock_out), 32'(0));
    check("reset_tick", 32'(dif.tick), 32'(0));
    check("reset_pending", 32'(dif.cfg_pending), 32'(0));
    reset = 1'b0;
    dif.enable = '1;
    count_high(0, 32, hi, tks);
    check("t1_high_cycles", 32'(hi), 32'(16));
    check("t1_ticks", 32'(tks), 32'(4));
    tick_gap(2, g);
    check("t1_period", 32'(g), 32'(8));

    // 2: mid-period write on ch1 waits for the wrap
    wait_pos(1, 3);
    write_cfg(1, 5, 2);
    check("t2_pending", 32'(dif.cfg_pending[1]), 32'(1));
    tick_gap(1, g);
    check("t2_new_period", 32'(g), 32'(5));
    check("t2_pending_cleared", 32'(dif.cfg_pending[1]), 32'(0));
    tick_gap(0, g);
    check("t2_ch0_unchanged", 32'(g), 32'(8));

    // 3: divisor clamp and zero high time
    write_cfg(2, 1, 1);
    tick_gap(2, g);
    check("t3_clamped_period", 32'(g), 32'(2));
    count_high(2, 10, hi, tks);
    check("t3_clamped_high", 32'(hi), 32'(5));
    write_cfg(2, 2, 0);
    run(4);
    count_high(2, 10, hi, tks);
    check("t3_high0_const", 32'(hi), 32'(0));
    check("t3_high0_ticks", 32'(tks), 32'(5));

    // 4: enable drop, re-enable, write while disabled
    wait_pos(0, 2);
    dif.enable[0] = 1'b0;
    step();
    check("t4_off_clock", 32'(dif.clock_out[0]), 32'(0));
    check("t4_off_tick", 32'(dif.tick[0]), 32'(0));
    run(3);
    dif.enable[0] = 1'b1;
    step();
    check("t4_reen_clock", 32'(dif.clock_out[0]), 32'(1));
    check("t4_reen_tick", 32'(dif.tick[0]), 32'(1));
    count_high(0, 7, hi, tks);
    check("t4_reen_high_rest", 32'(hi), 32'(3));
    dif.enable[0] = 1'b0;
    step();
    write_cfg(0, 6, 3);
    check("t4_disabled_write_pending", 32'(dif.cfg_pending[0]), 32'(0));
    dif.enable[0] = 1'b1;
    tick_gap(0, g);
    check("t4_disabled_write_period", 32'(g), 32'(6));

    // 5: write exactly on the wrap, and an out-of-range channel write
    wait_pos(3, 7);
    write_cfg(3, 6, 3);
    check("t5_wrap_pending", 32'(dif.cfg_pending[3]), 32'(0));
    tick_gap(3, g);
    check("t5_wrap_period", 32'(g), 32'(6));
    dif3.cfg_valid = 1'b1; dif3.cfg_ch = 2'd3; dif3.cfg_div = DIV_WIDTH'(5); dif3.cfg_high = DIV_WIDTH'(2);
    step();
    dif3.cfg_valid = 1'b0;
    run(20);

    // 6: reset mid-period with a write pending
    wait_pos(1, 1);
    write_cfg(1, 7, 3);
    check("t6_pending_before", 32'(dif.cfg_pending[1]), 32'(1));
    reset = 1'b1;
    step();
    check("t6_reset_clock", 32'(dif.clock_out), 32'(0));
    check("t6_reset_tick", 32'(dif.tick), 32'(0));
    check("t6_reset_pending", 32'(dif.cfg_pending), 32'(0));
    reset = 1'b0;
    tick_gap(1, g);
    check("t6_default_period", 32'(g), 32'(8));

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) dif.enable[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        dif.cfg_valid = 1'b1;
        dif.cfg_ch    = 2'($urandom_range(0, CH - 1));
        dif.cfg_div   = DIV_WIDTH'($urandom_range(0, 12));
        dif.cfg_high  = DIV_WIDTH'($urandom_range(0, 14));
      end
      reset = ($urandom_range(0, 499) == 0);
      step();
      dif.cfg_valid = 1'b0;
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
